// File: rtl/div11_rebuild.sv
// div11_rebuild: digit-serial inverse of the divide-by-11 stage.
// Rebuilds x = 11*q + r two quotient bits per cycle, LSB first. The
// 4-bit carry is the radix-4 remainder state the divider walks through,
// here run in reverse.
//
// Optional feature macro: DIV11_REBUILD_RANGE_CHECK_EN
//   defined   -> err flags r_in > 10 (presented only while out_valid)
//   undefined -> err tied low, no comparator
//
// state  | meaning
// IDLE   | waiting for an operand pair, in_ready=1
// RUN    | consuming one radix-4 quotient digit per cycle
// DONE   | x_out valid, held until out_ready
module div11_rebuild #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] q_in,
  input  logic [3:0]   r_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N+3:0] x_out,
  output logic         err
);

  // cnt must hold 0..N/2-1; the +1 keeps CW >= 1 for N=2
  localparam int CW = $clog2(N/2 + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  qreg;
  logic [N-1:0]  res;
  logic [N-1:0]  res_nxt;
  logic [3:0]    carry;
  logic [3:0]    carry_nxt;
  logic [CW-1:0] cnt;
  logic [5:0]    s;
  logic          last;

  // One digit step: low two bits of s become a result digit, the rest
  // (at most 12 even for r_in=15) carries into the next digit.
  always_comb begin
    s         = 6'(qreg[1:0]) * 6'd11 + 6'(carry);
    res_nxt   = (res >> 2) | (N'(s[1:0]) << (N - 2));
    carry_nxt = s[5:2];
  end

  assign last = (cnt == CW'(N / 2 - 1));

  // Handshake FSM and digit datapath; x_out is captured on the last
  // RUN edge so it is stable for the whole of DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      qreg  <= '0;
      res   <= '0;
      carry <= '0;
      cnt   <= '0;
      x_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            qreg  <= q_in;
            carry <= r_in;
            res   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          qreg  <= qreg >> 2;
          res   <= res_nxt;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          if (last) begin
            x_out <= {carry_nxt, res_nxt};
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

`ifdef DIV11_REBUILD_RANGE_CHECK_EN
  logic err_reg;

  // Latch the out-of-range flag with the operand; held through RUN/DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      err_reg <= (r_in > 4'd10);
    end
  end

  assign err = err_reg & out_valid;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_div11_rebuild.sv
// Self-checking bench for div11_rebuild (N=16). Expected values come from
// plain arithmetic: x = 11*q + r, err = (r > 10) only when the range-check
// macro is defined.
module tb_div11_rebuild;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  q_in;
  logic [3:0]    r_in;
  logic          out_valid;
  logic          out_ready;
  logic [N+3:0]  x_out;
  logic          err;

  int errors = 0;
  int checks = 0;

  div11_rebuild #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .q_in     (q_in),
    .r_in     (r_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [N+3:0] model_x(input int unsigned q, input int unsigned r);
    return (N+4)'(11 * q + r);
  endfunction

  function automatic logic model_err(input int unsigned r);
`ifdef DIV11_REBUILD_RANGE_CHECK_EN
    return (r > 10);
`else
    return 1'b0;
`endif
  endfunction

  // Drives one operand pair from IDLE (called at posedge+1) and waits for
  // out_valid with a bounded budget. lat = edges from accept to out_valid.
  // With hold=0 the result is consumed; with hold=1 the DUT is left in DONE.
  task automatic run_op(input logic [N-1:0] q, input logic [3:0] r, input bit hold,
                        output logic [N+3:0] x, output logic e, output int lat);
    in_valid = 1'b1;
    q_in     = q;
    r_in     = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    q_in     = $urandom();
    r_in     = 4'($urandom());
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
    x = x_out;
    e = err;
    if (!hold) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; q_in = '0; r_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
    checks++; if (x_out !== '0)       begin errors++; $display("FAIL reset x_out got=%0d want=0", x_out); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset err got=%b want=0", err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_range_limits();
    logic [N+3:0] x; logic e; int lat;
    run_op(16'd5957, 4'd8, 1'b0, x, e, lat);
    checks++; if (x !== 20'h0FFFF) begin errors++; $display("FAIL range_limits x_out got=%0d want=65535", x); end
    checks++; if (lat != 8)        begin errors++; $display("FAIL range_limits latency got=%0d want=8", lat); end
  endtask

  task automatic test_zero_and_max();
    logic [N+3:0] x; logic e; int lat;
    run_op(16'd0, 4'd0, 1'b0, x, e, lat);
    checks++; if (x !== 20'd0) begin errors++; $display("FAIL zero x_out got=%0d want=0", x); end
    run_op(16'd65535, 4'd10, 1'b0, x, e, lat);
    checks++; if (x !== 20'hAFFFF) begin errors++; $display("FAIL max x_out got=%0d want=720895", x); end
    checks++; if (e !== 1'b0)      begin errors++; $display("FAIL max err got=%b want=0", e); end
  endtask

  task automatic test_backpressure();
    logic [N+3:0] x; logic e; int lat;
    logic [N+3:0] want;
    want = model_x(1234, 7);
    run_op(16'd1234, 4'd7, 1'b1, x, e, lat);
    checks++; if (x !== want) begin errors++; $display("FAIL bp_result x_out got=%0d want=%0d", x, want); end
    in_valid = 1'b1; q_in = 16'hBEEF; r_in = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (x_out !== want || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d x_out=%0d out_valid=%b in_ready=%b want x_out=%0d out_valid=1 in_ready=0",
                 i, x_out, out_valid, in_ready, want);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release in_ready=%b out_valid=%b want in_ready=1 out_valid=0", in_ready, out_valid);
    end
    run_op(16'd4321, 4'd2, 1'b0, x, e, lat);
    want = model_x(4321, 2);
    checks++; if (x !== want) begin errors++; $display("FAIL back_to_back x_out got=%0d want=%0d", x, want); end
    checks++; if (lat != 8)   begin errors++; $display("FAIL back_to_back latency got=%0d want=8", lat); end
  endtask

  task automatic test_reset_during_run();
    logic [N+3:0] x; logic e; int lat;
    bit pulse;
    in_valid = 1'b1; q_in = 16'd999; r_in = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || x_out !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run in_ready=%b out_valid=%b x_out=%0d err=%b want 1 0 0 0", in_ready, out_valid, x_out, err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulse = 1;
    end
    checks++; if (pulse) begin errors++; $display("FAIL reset_no_pulse out_valid seen=1 want=0"); end
    run_op(16'd31000, 4'd9, 1'b0, x, e, lat);
    checks++;
    if (x !== model_x(31000, 9)) begin errors++; $display("FAIL after_reset x_out got=%0d want=%0d", x, model_x(31000, 9)); end
  endtask

  task automatic test_range_check();
    logic [N+3:0] x; logic e; int lat;
    run_op(16'd1, 4'd12, 1'b0, x, e, lat);
    checks++; if (x !== 20'd23)        begin errors++; $display("FAIL rc12 x_out got=%0d want=23", x); end
    checks++; if (e !== model_err(12)) begin errors++; $display("FAIL rc12 err got=%b want=%b", e, model_err(12)); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL rc_idle err got=%b want=0", err); end
    run_op(16'd1, 4'd10, 1'b0, x, e, lat);
    checks++; if (e !== 1'b0)          begin errors++; $display("FAIL rc10 err got=%b want=0", e); end
    for (int r = 11; r < 16; r++) begin
      logic [N-1:0] q;
      q = 16'($urandom());
      run_op(q, 4'(r), 1'b0, x, e, lat);
      checks++;
      if (x !== model_x(q, r) || e !== model_err(r)) begin
        errors++; $display("FAIL rc_sweep q=%0d r=%0d x_out=%0d err=%b want %0d %b", q, r, x, e, model_x(q, r), model_err(r));
      end
    end
  endtask

  task automatic test_random_sweep();
    logic [N+3:0] x; logic e; int lat;
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] q; logic [3:0] r;
      q = 16'($urandom_range(65535));
      r = 4'($urandom_range(10));
      run_op(q, r, 1'b0, x, e, lat);
      checks++;
      if (x !== model_x(q, r) || e !== 1'b0 || lat != 8) begin
        errors++; $display("FAIL random q=%0d r=%0d x_out=%0d err=%b lat=%0d want %0d 0 8", q, r, x, e, lat, model_x(q, r));
      end
    end
  endtask

  task automatic test_divider_feedback();
    logic [N+3:0] x; logic e; int lat;
    for (int i = 0; i < 800; i++) begin
      int unsigned d;
      logic [N-1:0] q; logic [3:0] r;
      d = $urandom_range(720895);
      q = 16'(d / 11);
      r = 4'(d % 11);
      run_op(q, r, 1'b0, x, e, lat);
      checks++;
      if (x !== 20'(d)) begin
        errors++; $display("FAIL divider_feedback d=%0d q=%0d r=%0d x_out=%0d", d, q, r, x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_range_limits();
    test_zero_and_max();
    test_backpressure();
    test_reset_during_run();
    test_range_check();
    test_random_sweep();
    test_divider_feedback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
